// File: rtl/cpu_io_pkg.sv
// Shared definitions for the CPU I/O blocks: pager state encoding, LED width, button latency.
// Pure declarations, no logic, no latency and no backpressure of its own.
package cpu_io_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SHOW = 1'b1
    } state_t;

    localparam int LED_W   = 8;
    // Synchroniser depth; a raw rising level reaches the consumer this many edges after first sampling.
    localparam int BTN_LAT = 2;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// Push-button conditioning: synchroniser chain plus a one-cycle rising-edge pulse.
// The edge pulse is valid BTN_LAT-1 cycles after first sampling; no debounce, no backpressure.
module btn_edge_det
    import cpu_io_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic btn_in,
    output logic btn_edge
);

    logic [BTN_LAT-1:0] sync;
    logic               prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[BTN_LAT-2:0], btn_in};
            prev <= sync[BTN_LAT-1];
        end
    end

    // A held button gives exactly one pulse: prev catches up one cycle later.
    assign btn_edge = sync[BTN_LAT-1] & ~prev;

endmodule

// File: rtl/result_pager.sv
// Latches a multi-byte result from the core and pages it onto the LEDs one byte per button press.
// Result accepted in one edge; pages advance BTN_LAT edges after a press; res_ready is low while paging.
// Optional RESULT_PAGER_AUTOADV_EN adds an idle-timeout auto-advance of AUTO_CYCLES cycles.
module result_pager
    import cpu_io_pkg::*;
#(
    parameter  int NBYTES      = 2,
    parameter  int AUTO_CYCLES = 1000000,
    localparam int IDX_W       = idx_width(NBYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [LED_W*NBYTES-1:0] res_data,
    input  logic                    res_valid,
    output logic                    res_ready,
    input  logic                    btn_in,
    output logic [LED_W-1:0]        led_out,
    output logic [IDX_W-1:0]        page_idx,
    output logic                    busy
);

    state_t                    state;
    logic                      armed;
    logic [LED_W*NBYTES-1:0]   shadow;
    logic                      btn_edge;
    logic                      advance;
    logic                      last_page;
    logic [LED_W-1:0]          next_byte;

    btn_edge_det u_btn (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn_in),
        .btn_edge (btn_edge)
    );

    // armed keeps res_ready low during reset and for the release edge itself.
    assign res_ready = armed && (state == ST_IDLE);
    assign last_page = (page_idx == IDX_W'(NBYTES - 1));

    always_comb begin
        next_byte = '0;
        for (int i = 0; i < NBYTES; i++) begin
            if (i == int'(page_idx) + 1) begin
                next_byte = shadow[LED_W*i +: LED_W];
            end
        end
    end

`ifdef RESULT_PAGER_AUTOADV_EN
    localparam int CNT_W = idx_width(AUTO_CYCLES);

    logic [CNT_W-1:0] auto_cnt;
    logic             auto_hit;

    assign auto_hit = (state == ST_SHOW) && (auto_cnt == CNT_W'(AUTO_CYCLES - 1));
    // A press coinciding with the timeout still yields a single advance.
    assign advance  = btn_edge | auto_hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            auto_cnt <= '0;
        end else if (state != ST_SHOW || advance) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + CNT_W'(1);
        end
    end
`else
    assign advance = btn_edge;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            armed    <= 1'b0;
            shadow   <= '0;
            led_out  <= '0;
            page_idx <= '0;
            busy     <= 1'b0;
        end else begin
            armed <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (res_valid && res_ready) begin
                        shadow   <= res_data;
                        page_idx <= '0;
                        led_out  <= res_data[LED_W-1:0];
                        busy     <= 1'b1;
                        state    <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (advance) begin
                        if (last_page) begin
                            // Last byte stays on the LEDs after the transfer completes.
                            busy  <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            page_idx <= page_idx + IDX_W'(1);
                            led_out  <= next_byte;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
